// File: rtl/segment_resp_collector_pkg.sv
// Shared types and defaults for the segment response collector.
package segment_resp_collector_pkg;

    localparam int unsigned SegMaxOutstanding = 4;
    localparam int unsigned ExcWidth          = 64;

    typedef struct packed {
        logic [ExcWidth-1:0] cause;
        logic [ExcWidth-1:0] tval;
    } seg_exc_t;

endpackage

// File: rtl/segment_resp_collector_fifo.sv
// In-order tag FIFO holding the segment index of each outstanding micro-op.
// Occupancy is tracked by the caller, which never pushes when full nor pops when empty.
module segment_resp_collector_fifo #(
    parameter int unsigned Depth     = 4,
    parameter int unsigned DataWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/segment_resp_collector.sv
// Matches in-order backend responses to issued segment micro-ops, captures the first
// exception and emits one aggregated completion per segment memory op.
module segment_resp_collector
    import segment_resp_collector_pkg::*;
#(
    parameter int unsigned MaxOutstanding = SegMaxOutstanding,
    parameter int unsigned VstartWidth    = 16,
    parameter int unsigned NfWidth        = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   ara_idle_i,
    input  logic                   start_i,
    input  logic [VstartWidth-1:0] vstart_i,
    input  logic [VstartWidth-1:0] vl_i,
    input  logic                   is_vload_i,
    input  logic                   uop_issue_i,
    input  logic [VstartWidth-1:0] uop_seg_i,
    input  logic                   uop_last_i,
    input  logic                   resp_valid_i,
    input  logic                   resp_exc_valid_i,
    input  logic [63:0]            resp_exc_cause_i,
    input  logic [63:0]            resp_exc_tval_i,
    output logic                   stall_issue_o,
    output logic                   abort_o,
    output logic                   busy_o,
    output logic                   done_valid_o,
    output logic                   done_exc_valid_o,
    output logic [63:0]            done_exc_cause_o,
    output logic [63:0]            done_exc_tval_o,
    output logic [VstartWidth-1:0] done_vstart_o,
    output logic                   load_complete_o,
    output logic                   store_complete_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;

    if (MaxOutstanding < 2 || (MaxOutstanding & (MaxOutstanding - 1)) != 0 || NfWidth == 0)
    begin : g_bad_params
        $error("segment_resp_collector: MaxOutstanding must be a power of two >= 2");
    end

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        count_q, count_d;
    logic                   is_vload_q;
    logic [VstartWidth-1:0] vstart_q, vl_q;
    logic                   exc_q;
    seg_exc_t               exc_info_q;
    logic [VstartWidth-1:0] exc_tag_q;
    logic [VstartWidth-1:0] head_tag;
    logic                   active, full, empty, push, pop, first_exc;

    assign active    = (state_q == COLLECT) || (state_q == DRAIN);
    assign full      = (count_q == CntW'(MaxOutstanding));
    assign empty     = (count_q == '0);
    assign push      = uop_issue_i && (state_q == COLLECT) && !full;
    assign pop       = resp_valid_i && active && !empty;
    assign first_exc = resp_valid_i && resp_exc_valid_i && active && !exc_q;

    segment_resp_collector_fifo #(
        .Depth     (MaxOutstanding),
        .DataWidth (VstartWidth)
    ) i_tag_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push),
        .data_i (uop_seg_i),
        .pop_i  (pop),
        .data_o (head_tag)
    );

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = (vstart_i < vl_i) ? COLLECT : DONE;
            COLLECT: if (first_exc || (push && uop_last_i)) state_d = DRAIN;
            DRAIN:   if (empty && ara_idle_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            count_q    <= '0;
            is_vload_q <= 1'b0;
            vstart_q   <= '0;
            vl_q       <= '0;
            exc_q      <= 1'b0;
            exc_info_q <= '0;
            exc_tag_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (state_q == IDLE && start_i) begin
                is_vload_q <= is_vload_i;
                vstart_q   <= vstart_i;
                vl_q       <= vl_i;
                exc_q      <= 1'b0;
            end else if (first_exc) begin
                // A fault with no tag outstanding is attributed to the op's first segment.
                exc_q            <= 1'b1;
                exc_info_q.cause <= resp_exc_cause_i;
                exc_info_q.tval  <= resp_exc_tval_i;
                exc_tag_q        <= empty ? vstart_q : head_tag;
            end
        end
    end

    assign stall_issue_o    = full || (state_q != COLLECT);
    assign abort_o          = first_exc;
    assign busy_o           = (state_q != IDLE);
    assign done_valid_o     = (state_q == DONE);
    assign done_exc_valid_o = done_valid_o && exc_q;
    assign done_exc_cause_o = exc_info_q.cause;
    assign done_exc_tval_o  = exc_info_q.tval;
    assign done_vstart_o    = exc_q ? exc_tag_q : vl_q;
    assign load_complete_o  = done_valid_o && is_vload_q;
    assign store_complete_o = done_valid_o && !is_vload_q;

`ifndef SYNTHESIS
    resp_while_empty_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(resp_valid_i && active && empty && !resp_exc_valid_i));
`endif

endmodule

// File: tb/tb_segment_resp_collector.sv
// Randomized bench for segment_resp_collector against a queue-based reference model.
module tb_segment_resp_collector;

    localparam int unsigned MaxOut = 4;
    localparam int unsigned VW     = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          ara_idle_i, start_i, is_vload_i, uop_issue_i, uop_last_i;
    logic [VW-1:0] vstart_i, vl_i, uop_seg_i;
    logic          resp_valid_i, resp_exc_valid_i;
    logic [63:0]   resp_exc_cause_i, resp_exc_tval_i;
    logic          stall_issue_o, abort_o, busy_o, done_valid_o, done_exc_valid_o;
    logic [63:0]   done_exc_cause_o, done_exc_tval_o;
    logic [VW-1:0] done_vstart_o;
    logic          load_complete_o, store_complete_o;

    segment_resp_collector #(.MaxOutstanding(MaxOut), .VstartWidth(VW), .NfWidth(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ara_idle_i(ara_idle_i), .start_i(start_i),
        .vstart_i(vstart_i), .vl_i(vl_i), .is_vload_i(is_vload_i), .uop_issue_i(uop_issue_i),
        .uop_seg_i(uop_seg_i), .uop_last_i(uop_last_i), .resp_valid_i(resp_valid_i),
        .resp_exc_valid_i(resp_exc_valid_i), .resp_exc_cause_i(resp_exc_cause_i),
        .resp_exc_tval_i(resp_exc_tval_i), .stall_issue_o(stall_issue_o), .abort_o(abort_o),
        .busy_o(busy_o), .done_valid_o(done_valid_o), .done_exc_valid_o(done_exc_valid_o),
        .done_exc_cause_o(done_exc_cause_o), .done_exc_tval_o(done_exc_tval_o),
        .done_vstart_o(done_vstart_o), .load_complete_o(load_complete_o),
        .store_complete_o(store_complete_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase of the op plus a queue of outstanding segment tags.
    typedef enum {M_IDLE, M_COLLECT, M_DRAIN, M_DONE} mphase_e;
    mphase_e       m_phase;
    logic [VW-1:0] m_q[$];
    logic          m_load, m_exc;
    logic [VW-1:0] m_vstart, m_vl, m_tag;
    logic [63:0]   m_cause, m_tval;

    function automatic bit m_busy_op();
        return (m_phase == M_COLLECT) || (m_phase == M_DRAIN);
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE; m_q.delete(); m_exc = 0; m_load = 0;
        m_vstart = '0; m_vl = '0; m_tag = '0; m_cause = '0; m_tval = '0;
    endtask

    task automatic model_update();
        bit accepted, popped, first, drained;
        case (m_phase)
            M_IDLE: if (start_i) begin
                m_load = is_vload_i; m_vstart = vstart_i; m_vl = vl_i; m_exc = 0;
                m_phase = (vstart_i < vl_i) ? M_COLLECT : M_DONE;
            end
            M_COLLECT, M_DRAIN: begin
                drained  = (m_q.size() == 0);
                accepted = uop_issue_i && (m_phase == M_COLLECT) && (m_q.size() < MaxOut);
                popped   = resp_valid_i && (m_q.size() > 0);
                first    = resp_valid_i && resp_exc_valid_i && !m_exc;
                if (first) begin
                    m_exc = 1; m_cause = resp_exc_cause_i; m_tval = resp_exc_tval_i;
                    m_tag = (m_q.size() > 0) ? m_q[0] : m_vstart;
                end
                if (popped)   void'(m_q.pop_front());
                if (accepted) m_q.push_back(uop_seg_i);
                if (m_phase == M_COLLECT) begin
                    if (first || (accepted && uop_last_i)) m_phase = M_DRAIN;
                end else if (drained && ara_idle_i) begin
                    m_phase = M_DONE;
                end
            end
            default: m_phase = M_IDLE;
        endcase
    endtask

    task automatic compare_outputs();
        bit done;
        done = (m_phase == M_DONE);
        check_val("stall", stall_issue_o, (m_q.size() == MaxOut) || (m_phase != M_COLLECT));
        check_val("busy", busy_o, m_phase != M_IDLE);
        check_val("abort", abort_o, m_busy_op() && resp_valid_i && resp_exc_valid_i && !m_exc);
        check_val("done_valid", done_valid_o, done);
        if (done) begin
            check_val("done_exc_valid", done_exc_valid_o, m_exc);
            check_val("done_vstart", done_vstart_o, m_exc ? m_tag : m_vl);
            check_val("load_complete", load_complete_o, m_load);
            check_val("store_complete", store_complete_o, !m_load);
            if (m_exc) begin
                check_val("done_cause", done_exc_cause_o, m_cause);
                check_val("done_tval", done_exc_tval_o, m_tval);
            end
        end
    endtask

    // Inputs are held from just after a rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk_i);
        compare_outputs();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        ara_idle_i = 1; start_i = 0; vstart_i = '0; vl_i = '0; is_vload_i = 0;
        uop_issue_i = 0; uop_seg_i = '0; uop_last_i = 0; resp_valid_i = 0;
        resp_exc_valid_i = 0; resp_exc_cause_i = '0; resp_exc_tval_i = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_ni = 0;
        #1;
        model_reset();
        check_val("rst_busy", busy_o, 1'b0);
        check_val("rst_stall", stall_issue_o, 1'b1);
        check_val("rst_done_valid", done_valid_o, 1'b0);
        check_val("rst_abort", abort_o, 1'b0);
        @(posedge clk_i);
        #1 rst_ni = 1;
    endtask

    task automatic run_op(input logic [VW-1:0] vs, input logic [VW-1:0] vl, input bit ld,
                          input int reset_at);
        logic [VW-1:0] seg;
        bit            last_sent;
        int            cyc;
        clear_inputs();
        start_i = 1; vstart_i = vs; vl_i = vl; is_vload_i = ld;
        step();
        start_i = 0;
        seg = vs; last_sent = 0; cyc = 0;
        while (m_phase != M_IDLE && cyc < 300) begin
            if (cyc == reset_at) begin
                apply_reset();
                return;
            end
            clear_inputs();
            uop_seg_i   = seg;
            uop_last_i  = (seg == m_vl - 16'd1);
            uop_issue_i = ((m_phase == M_COLLECT) && !last_sent && ($urandom_range(3) != 0))
                          || ($urandom_range(15) == 0);
            if (m_q.size() > 0) begin
                resp_valid_i     = $urandom_range(1);
                resp_exc_valid_i = resp_valid_i && ($urandom_range(7) == 0);
            end else if (m_busy_op() && $urandom_range(31) == 0) begin
                resp_valid_i = 1; resp_exc_valid_i = 1;
            end
            resp_exc_cause_i = {$urandom, $urandom};
            resp_exc_tval_i  = {$urandom, $urandom};
            ara_idle_i       = ($urandom_range(9) < 7);
            if ($urandom_range(19) == 0) begin
                start_i = 1; vstart_i = VW'($urandom_range(9)); vl_i = VW'($urandom_range(9));
            end
            if (uop_issue_i && m_phase == M_COLLECT && m_q.size() < MaxOut) begin
                if (uop_last_i) last_sent = 1;
                seg = seg + 16'd1;
            end
            step();
            cyc++;
        end
        if (m_phase != M_IDLE) begin
            check_val("op_timeout", 1'b1, 1'b0);
            apply_reset();
        end
    endtask

    initial begin
        rst_ni = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        compare_outputs();
        check_val("rst_fifo_count_stall", stall_issue_o, 1'b1);
        @(posedge clk_i);
        #1 rst_ni = 1;
        step();
        run_op(16'd0, 16'd4, 1'b1, -1);
        run_op(16'd5, 16'd5, 1'b0, -1);
        run_op(16'd7, 16'd3, 1'b1, -1);
        run_op(16'd0, 16'd8, 1'b0, 6);
        run_op(16'd1, 16'd3, 1'b0, -1);
        for (int i = 0; i < 60; i++) begin
            run_op(VW'($urandom_range(9)), VW'($urandom_range(9)), 1'($urandom_range(1)),
                   ($urandom_range(7) == 0) ? int'($urandom_range(10)) : -1);
            clear_inputs();
            repeat ($urandom_range(2)) step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
